// File: rtl/fa_pwr_pkg.sv
// fa_pwr_pkg: types and constants shared by the fa_pwr_seq sequencer, its
// operand FIFO and its bus interface.
//   FA_W           : adder operand width
//   fa_pwr_state_e : power/sequencing FSM states
//   fa_op_t        : one operand triple {cin, x, y}
//   max3()         : elaboration helper for sizing shared counters
package fa_pwr_pkg;

  localparam int FA_W = 4;

  typedef enum logic [2:0] {
    OFF,
    PWR_UP,
    ACTIVE,
    SETTLE,
    ISO
  } fa_pwr_state_e;

  typedef struct packed {
    logic            cin;
    logic [FA_W-1:0] x;
    logic [FA_W-1:0] y;
  } fa_op_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fa_pwr_seq_if.sv
// fa_pwr_seq_if: all non-clock signals of the fa_pwr_seq block.
//   upstream  : in_valid/in_ready/in_x/in_y/in_cin   (operand stream)
//   result    : out_valid/out_ready/out_sum/out_cout (result stream)
//   adder     : fa_x/fa_y/fa_cin out, fa_sum/fa_cout back
//   power     : sw_ctrl_net, iso_en, busy
// modport slave is the sequencer; modport master is its environment
// (producer, consumer and adder domain together).
interface fa_pwr_seq_if;
  import fa_pwr_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [FA_W-1:0] in_x;
  logic [FA_W-1:0] in_y;
  logic            in_cin;
  logic            out_valid;
  logic            out_ready;
  logic [FA_W-1:0] out_sum;
  logic            out_cout;
  logic [FA_W-1:0] fa_x;
  logic [FA_W-1:0] fa_y;
  logic            fa_cin;
  logic [FA_W-1:0] fa_sum;
  logic            fa_cout;
  logic            sw_ctrl_net;
  logic            iso_en;
  logic            busy;

  modport master (
    output in_valid, in_x, in_y, in_cin, out_ready, fa_sum, fa_cout,
    input  in_ready, out_valid, out_sum, out_cout, fa_x, fa_y, fa_cin,
           sw_ctrl_net, iso_en, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_cin, out_ready, fa_sum, fa_cout,
    output in_ready, out_valid, out_sum, out_cout, fa_x, fa_y, fa_cin,
           sw_ctrl_net, iso_en, busy
  );

endinterface

// File: rtl/fa_op_fifo.sv
// fa_op_fifo: synchronous FIFO of operand triples.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i     : write wdata_i (caller only pushes when count_o < DEPTH)
//   pop_i      : advance read pointer (caller only pops when non-empty)
//   wdata_i    : triple to store
//   rdata_o    : oldest stored triple (valid while non-empty)
//   count_o    : number of stored entries, 0..DEPTH
module fa_op_fifo
  import fa_pwr_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  fa_op_t        wdata_i,
  output fa_op_t        rdata_o,
  output logic [CW-1:0] count_o
);

  fa_op_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fa_pwr_seq.sv
// fa_pwr_seq: operand sequencer and power-domain controller for a 4-bit
// ripple adder. Buffers operand triples, powers the adder domain up,
// drives one operand set at a time, captures sum/cout after a settle
// window and powers the domain down again after an idle timeout.
//   clk   : sole clock
//   rst_n : asynchronous active-low reset
//   bus   : fa_pwr_seq_if.slave (operand in, result out, adder, power)
module fa_pwr_seq
  import fa_pwr_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PWR_UP_CYC = 8,
  parameter int SETTLE_CYC = 2,
  parameter int IDLE_CYC   = 16
) (
  input logic          clk,
  input logic          rst_n,
  fa_pwr_seq_if.slave  bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(max3(PWR_UP_CYC, SETTLE_CYC, IDLE_CYC) + 1);

  fa_pwr_state_e   state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;   // PWR_UP / SETTLE dwell
  logic [CNT_W-1:0] idle_q, idle_d;     // consecutive idle ACTIVE cycles
  fa_op_t          op_q, op_d;          // operands presented to the adder
  logic            out_valid_q, out_valid_d;
  logic [FA_W-1:0] out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d;
  logic            sw_q, sw_d;
  logic            iso_q, iso_d;

  logic            push;
  logic            pop;
  logic            in_ready;
  logic            fifo_empty;
  fa_op_t          fifo_wdata;
  fa_op_t          fifo_rdata;
  logic [CW-1:0]   fifo_count;

  assign in_ready   = (fifo_count < CW'(DEPTH));
  assign push       = bus.in_valid & in_ready;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_wdata = '{cin: bus.in_cin, x: bus.in_x, y: bus.in_y};

  fa_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idle_d      = '0;
    op_d        = op_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      OFF: begin
        timer_d = '0;
        if (!fifo_empty) state_d = PWR_UP;
      end
      PWR_UP: begin
        if (timer_q == CNT_W'(PWR_UP_CYC - 1)) begin
          timer_d = '0;
          state_d = ACTIVE;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ACTIVE: begin
        // Popping only when the result port is free (or being freed this
        // cycle) is what keeps a capture from overwriting a pending result.
        if (!fifo_empty && (!out_valid_q || bus.out_ready)) begin
          pop     = 1'b1;
          op_d    = fifo_rdata;
          timer_d = '0;
          state_d = SETTLE;
        end else if (fifo_empty && !out_valid_q) begin
          // Leave on the cycle the count would reach IDLE_CYC.
          if (idle_q == CNT_W'(IDLE_CYC - 1)) state_d = ISO;
          else                                idle_d  = idle_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (timer_q == CNT_W'(SETTLE_CYC - 1)) begin
          out_valid_d = 1'b1;
          out_sum_d   = bus.fa_sum;
          out_cout_d  = bus.fa_cout;
          timer_d     = '0;
          state_d     = ACTIVE;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ISO:     state_d = OFF;
      default: state_d = OFF;
    endcase

    // Power controls are registered from the next state so they change
    // together with the state register.
    sw_d  = (state_d != OFF);
    iso_d = (state_d != ACTIVE) && (state_d != SETTLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OFF;
      timer_q     <= '0;
      idle_q      <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      sw_q        <= 1'b0;
      iso_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idle_q      <= idle_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      sw_q        <= sw_d;
      iso_q       <= iso_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sum     = out_sum_q;
  assign bus.out_cout    = out_cout_q;
  assign bus.fa_x        = op_q.x;
  assign bus.fa_y        = op_q.y;
  assign bus.fa_cin      = op_q.cin;
  assign bus.sw_ctrl_net = sw_q;
  assign bus.iso_en      = iso_q;
  assign bus.busy        = (state_q != OFF) || !fifo_empty || out_valid_q;

endmodule

// File: tb/tb_fa_pwr_seq.sv
// tb_fa_pwr_seq: directed + randomized bench for fa_pwr_seq. A behavioural
// adder sits on the fa_* pins; expected results come from plain x+y+cin
// arithmetic held in an ordered scoreboard, and timing points come from
// the latency formulas of the block.
module tb_fa_pwr_seq;

  localparam int DEPTH = 4;
  localparam int PWR   = 8;
  localparam int SET   = 2;
  localparam int IDLE  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fa_pwr_seq_if bus();

  fa_pwr_seq #(
    .DEPTH(DEPTH), .PWR_UP_CYC(PWR), .SETTLE_CYC(SET), .IDLE_CYC(IDLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Adder domain: outputs are meaningless while clamped.
  logic [4:0] fa_full;
  assign fa_full     = {1'b0, bus.fa_x} + {1'b0, bus.fa_y} + {4'b0, bus.fa_cin};
  assign bus.fa_sum  = bus.iso_en ? 4'bx : fa_full[3:0];
  assign bus.fa_cout = bus.iso_en ? 1'bx : fa_full[4];

  int         total = 0;
  int         bad   = 0;
  int         cycle = 0;
  int         n_res = 0;
  logic [4:0] exp_q[$];
  int         hs_cyc[$];

  function automatic logic [4:0] ref_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return s[4:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: account for handshakes in flight, then sample #1
  // after the edge.
  task automatic step();
    logic [4:0] e;
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_add(bus.in_x, bus.in_y, bus.in_cin));
    if (bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'd0;
      check("result", {bus.out_cout, bus.out_sum}, e);
      $display("cycle %0d result %0d: sum=%0d cout=%0b expected=%0d",
               cycle, n_res, bus.out_sum, bus.out_cout, e);
      hs_cyc.push_back(cycle);
      n_res++;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic c);
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_cin   = c;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < budget) begin
      step();
      n++;
    end
    check(tag, bus.out_valid, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_result"},    {bus.out_cout, bus.out_sum}, 0);
    check({tag, "_fa_ops"},    {bus.fa_cin, bus.fa_x, bus.fa_y}, 0);
    check({tag, "_sw"},        bus.sw_ctrl_net, 0);
    check({tag, "_iso"},       bus.iso_en, 1);
    check({tag, "_busy"},      bus.busy, 0);
  endtask

  initial begin
    int t, u, n, k, base, hold;
    logic acc;
    logic [3:0] ox[6];
    logic [3:0] oy[6];
    logic       oc[6];
    logic [3:0] rx, ry;
    logic       rc;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (2) step();
    check("off_idle_sw", bus.sw_ctrl_net, 0);

    // Cold start from OFF.
    t = cycle;
    drive(4'd3, 4'd5, 1'b1);
    step(); bus.in_valid = 1'b0;                          // t+1
    check("cold_sw_t1", bus.sw_ctrl_net, 0);
    check("cold_busy", bus.busy, 1);
    step();                                               // t+2
    check("cold_sw_t2", bus.sw_ctrl_net, 1);
    while (cycle < t + 1 + PWR) step();                   // t+9
    check("cold_iso_held", bus.iso_en, 1);
    step();                                               // t+10
    check("cold_iso_release", bus.iso_en, 0);
    step();                                               // t+11
    check("cold_fa_ops", {bus.fa_cin, bus.fa_x, bus.fa_y}, {1'b1, 4'd3, 4'd5});
    while (cycle < t + 2 + PWR + SET) step();             // t+12
    check("cold_valid_early", bus.out_valid, 0);
    step();                                               // t+13
    check("cold_valid", bus.out_valid, 1);
    check("cold_result", {bus.out_cout, bus.out_sum}, {1'b0, 4'd9});
    bus.out_ready = 1'b1;
    step();

    // Warm latency with carry out and sum wrap.
    t = cycle;
    drive(4'd8, 4'd8, 1'b0);
    step(); bus.in_valid = 1'b0;                          // t+1
    step();                                               // t+2
    check("warm_fa_ops", {bus.fa_cin, bus.fa_x, bus.fa_y}, {1'b0, 4'd8, 4'd8});
    step();                                               // t+3
    check("warm_valid_early", bus.out_valid, 0);
    step();                                               // t+4
    check("warm_valid", bus.out_valid, 1);
    check("warm_result", {bus.out_cout, bus.out_sum}, {1'b1, 4'd0});

    // Idle power-down, then a push during ISO.
    u = cycle;
    step();
    while (cycle < u + IDLE) step();                      // u+16
    check("pd_active_before", bus.iso_en, 0);
    step();                                               // u+17
    check("pd_iso", bus.iso_en, 1);
    check("pd_iso_sw", bus.sw_ctrl_net, 1);
    drive(4'd15, 4'd15, 1'b1);
    step(); bus.in_valid = 1'b0;                          // u+18
    check("pd_sw_off", bus.sw_ctrl_net, 0);
    step();                                               // u+19
    check("repower_sw", bus.sw_ctrl_net, 1);
    wait_valid(40, "repower_valid");
    check("repower_result", {bus.out_cout, bus.out_sum}, {1'b1, 4'd15});
    step();

    // Back-to-back operations with the consumer always ready.
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom));
      step();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (hs_cyc.size() < 4 && n < 60) begin step(); n++; end
    check("b2b_count", hs_cyc.size(), 4);
    for (int i = 0; i + 1 < hs_cyc.size(); i++)
      check("b2b_gap", hs_cyc[i+1] - hs_cyc[i], SET + 1);

    // Full FIFO and backpressure, starting from a powered-down domain.
    n = 0;
    while (bus.sw_ctrl_net && n < 100) begin step(); n++; end
    check("bp_off", bus.sw_ctrl_net, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ox[i] = 4'($urandom); oy[i] = 4'($urandom); oc[i] = 1'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      drive(ox[i], oy[i], oc[i]);
      check("bp_ready", bus.in_ready, 1);
      step();
    end
    check("bp_full", bus.in_ready, 0);
    k = 4; base = n_res; n = 0; hold = 0;
    while ((k < 6 || n_res - base < 6) && n < 600) begin
      bus.in_valid = (k < 6);
      if (k < 6) begin bus.in_x = ox[k]; bus.in_y = oy[k]; bus.in_cin = oc[k]; end
      if (bus.out_valid && hold < 3) begin
        if (exp_q.size() != 0) check("bp_hold", {bus.out_cout, bus.out_sum}, exp_q[0]);
        hold++;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = bus.out_valid;
        if (bus.out_valid) hold = 0;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      n++;
      if (acc) k++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("bp_results", n_res - base, 6);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) == 0);
      bus.in_x      = 4'($urandom);
      bus.in_y      = 4'($urandom);
      bus.in_cin    = 1'($urandom);
      bus.out_ready = 1'($urandom);
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin step(); n++; end
    check("rand_drain", exp_q.size(), 0);

    // Asynchronous reset in the middle of SETTLE.
    drive(4'($urandom), 4'($urandom), 1'($urandom));
    step(); bus.in_valid = 1'b0;
    wait_valid(40, "pre_rst_valid");
    step();
    t = cycle;
    drive(4'd6, 4'd7, 1'b1);
    step(); bus.in_valid = 1'b0;                          // t+1
    step();                                               // t+2
    check("mid_settle_fa", {bus.fa_cin, bus.fa_x, bus.fa_y}, {1'b1, 4'd6, 4'd7});
    check("mid_settle_iso", bus.iso_en, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Cold start after reset.
    rx = 4'($urandom); ry = 4'($urandom); rc = 1'($urandom);
    t = cycle;
    drive(rx, ry, rc);
    step(); bus.in_valid = 1'b0;
    while (cycle < t + 2 + PWR + SET) step();             // t+12
    check("post_rst_valid_early", bus.out_valid, 0);
    step();                                               // t+13
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_result", {bus.out_cout, bus.out_sum}, ref_add(rx, ry, rc));
    bus.out_ready = 1'b1;
    step();
    check("post_rst_consumed", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
